// File: rtl/vga_frame_regs.sv
// Frame-synchronous shadow/active register bank feeding the VGA controller; commit latency 1 clk after vsync fall.
// No backpressure: writes are always accepted, and the commit is deferred while hold is high or nothing is dirty.
module vga_frame_regs #(
    parameter int         FRAME_CNT_W = 16,
    parameter logic [2:0] RESET_MODE  = 3'd0
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [3:0]             wr_sel,
    input  logic [31:0]            wr_data,
    input  logic                   hold,
    input  logic                   vs_n,
    output logic [31:0]            block1x,
    output logic [31:0]            block1y,
    output logic [31:0]            block2x,
    output logic [31:0]            block2y,
    output logic [31:0]            block3x,
    output logic [31:0]            block3y,
    output logic [31:0]            block4x,
    output logic [31:0]            block4y,
    output logic [31:0]            score,
    output logic [31:0]            blockType,
    output logic [31:0]            screenMode,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   commit_pulse,
    output logic                   pending,
    output logic                   sel_err
);

    localparam int          NWORDS   = 11;
    localparam int          MODE_IDX = 10;
    localparam logic [31:0] MODE_RST = {RESET_MODE, 29'd0};
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]            shadow_q [NWORDS];
    logic [31:0]            shadow_d [NWORDS];
    logic [31:0]            active_q [NWORDS];
    logic [31:0]            active_d [NWORDS];
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   vs_d_q;
    logic                   pending_q, pending_d;
    logic                   commit_pulse_q, sel_err_q;
    logic                   vs_fall, wr_valid, commit;

    assign vs_fall  = vs_d_q & ~vs_n;
    assign wr_valid = wr_en & (wr_sel <= 4'd10);
    assign commit   = vs_fall & pending_q & ~hold;

    // Commit reads the pre-edge shadow, so a write in the commit cycle waits for the next frame.
    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (wr_valid) begin
            shadow_d[wr_sel] = wr_data;
            pending_d        = 1'b1;
        end
        if (vs_fall) begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                shadow_q[i] <= (i == MODE_IDX) ? MODE_RST : 32'd0;
                active_q[i] <= (i == MODE_IDX) ? MODE_RST : 32'd0;
            end
            frame_cnt_q    <= '0;
            vs_d_q         <= 1'b1;
            pending_q      <= 1'b0;
            commit_pulse_q <= 1'b0;
            sel_err_q      <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            frame_cnt_q    <= frame_cnt_d;
            vs_d_q         <= vs_n;
            pending_q      <= pending_d;
            commit_pulse_q <= commit;
            sel_err_q      <= wr_en & (wr_sel > 4'd10);
        end
    end

    assign block1x      = active_q[0];
    assign block1y      = active_q[1];
    assign block2x      = active_q[2];
    assign block2y      = active_q[3];
    assign block3x      = active_q[4];
    assign block3y      = active_q[5];
    assign block4x      = active_q[6];
    assign block4y      = active_q[7];
    assign score        = active_q[8];
    assign blockType    = active_q[9];
    assign screenMode   = active_q[MODE_IDX];
    assign frame_cnt    = frame_cnt_q;
    assign commit_pulse = commit_pulse_q;
    assign pending      = pending_q;
    assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_vga_frame_regs.sv
// Directed bench for vga_frame_regs, run with a narrow frame counter so the wrap is reachable.
module tb_vga_frame_regs;

    localparam int          CW       = 8;
    localparam logic [31:0] MODE_RST = 32'h4000_0000;

    logic          vga_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          wr_en   = 1'b0;
    logic [3:0]    wr_sel  = 4'd0;
    logic [31:0]   wr_data = 32'd0;
    logic          hold    = 1'b0;
    logic          vs_n    = 1'b1;
    logic [31:0]   block1x, block1y, block2x, block2y, block3x, block3y, block4x, block4y;
    logic [31:0]   score, blockType, screenMode;
    logic [CW-1:0] frame_cnt;
    logic          commit_pulse, pending, sel_err;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 vga_clk = ~vga_clk;

    vga_frame_regs #(.FRAME_CNT_W(CW), .RESET_MODE(3'd2)) dut (
        .vga_clk(vga_clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .hold(hold), .vs_n(vs_n),
        .block1x(block1x), .block1y(block1y), .block2x(block2x), .block2y(block2y),
        .block3x(block3x), .block3y(block3y), .block4x(block4x), .block4y(block4y),
        .score(score), .blockType(blockType), .screenMode(screenMode),
        .frame_cnt(frame_cnt), .commit_pulse(commit_pulse), .pending(pending), .sel_err(sel_err)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] sel, input logic [31:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (block1x !== 32'd0) begin errors++; $display("FAIL rst_b1x got %h exp 0", block1x); end
        checks++; if (score !== 32'd0) begin errors++; $display("FAIL rst_score got %h exp 0", score); end
        checks++; if (blockType !== 32'd0) begin errors++; $display("FAIL rst_type got %h exp 0", blockType); end
        checks++; if (screenMode !== MODE_RST) begin errors++; $display("FAIL rst_mode got %h exp %h", screenMode, MODE_RST); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", pending); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_fcnt got %0d exp 0", frame_cnt); end
        checks++; if ({commit_pulse, sel_err} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b exp 00", {commit_pulse, sel_err}); end
    endtask

    task automatic test_basic_commit();
        do_write(4'd0, 32'd5);
        do_write(4'd8, 32'd100);
        checks++; if (block1x !== 32'd0 || score !== 32'd0) begin errors++; $display("FAIL pre_commit got %h/%h exp 0/0", block1x, score); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_set got %b exp 1", pending); end
        vs_n = 1'b0;
        #1;
        checks++; if (block1x !== 32'd0) begin errors++; $display("FAIL no_comb_path got %h exp 0", block1x); end
        tick(); exp_cnt++;
        checks++; if (block1x !== 32'd5 || score !== 32'd100) begin errors++; $display("FAIL commit got %h/%h exp 5/100", block1x, score); end
        checks++; if (commit_pulse !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL commit_flags got %b%b exp 10", commit_pulse, pending); end
        checks++; if (frame_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL fcnt1 got %0d exp %0d", frame_cnt, exp_cnt); end
        tick();
        checks++; if (commit_pulse !== 1'b0 || frame_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL pulse_len got %b cnt %0d exp 0 cnt %0d", commit_pulse, frame_cnt, exp_cnt); end
        vs_n = 1'b1; tick();
    endtask

    task automatic test_hold();
        do_write(4'd10, 32'h2000_0000);
        hold = 1'b1; vs_n = 1'b0;
        tick(); exp_cnt++;
        checks++; if (commit_pulse !== 1'b0 || screenMode !== MODE_RST) begin errors++; $display("FAIL hold_block got %b %h exp 0 %h", commit_pulse, screenMode, MODE_RST); end
        checks++; if (frame_cnt !== CW'(exp_cnt) || pending !== 1'b1) begin errors++; $display("FAIL hold_cnt got %0d p%b exp %0d p1", frame_cnt, pending, exp_cnt); end
        vs_n = 1'b1; tick();
        hold = 1'b0; tick(); tick();
        checks++; if (screenMode !== MODE_RST || commit_pulse !== 1'b0) begin errors++; $display("FAIL no_retry got %h %b exp %h 0", screenMode, commit_pulse, MODE_RST); end
        vs_n = 1'b0; tick(); exp_cnt++;
        checks++; if (screenMode !== 32'h2000_0000 || commit_pulse !== 1'b1) begin errors++; $display("FAIL hold_release got %h %b exp 20000000 1", screenMode, commit_pulse); end
        vs_n = 1'b1; tick();
    endtask

    task automatic test_back_to_back();
        do_write(4'd3, 32'd3);
        wr_en = 1'b1; wr_sel = 4'd3; wr_data = 32'd7; vs_n = 1'b0;
        tick(); exp_cnt++;
        wr_en = 1'b0;
        checks++; if (block2y !== 32'd3 || pending !== 1'b1) begin errors++; $display("FAIL same_cycle got %h p%b exp 3 p1", block2y, pending); end
        checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL same_cycle_pulse got %b exp 1", commit_pulse); end
        vs_n = 1'b1; tick();
        vs_n = 1'b0; tick(); exp_cnt++;
        checks++; if (block2y !== 32'd7 || pending !== 1'b0 || frame_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL second_commit got %h p%b c%0d exp 7 p0 c%0d", block2y, pending, frame_cnt, exp_cnt); end
        vs_n = 1'b1; tick();
    endtask

    task automatic test_sel_err();
        do_write(4'd12, 32'hFFFF_FFFF);
        checks++; if (sel_err !== 1'b1 || pending !== 1'b0) begin errors++; $display("FAIL sel_err got %b p%b exp 1 p0", sel_err, pending); end
        tick();
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL sel_err_len got %b exp 0", sel_err); end
        do_write(4'd1, 32'd9);
        vs_n = 1'b0; tick(); exp_cnt++;
        vs_n = 1'b1;
        checks++; if (block1y !== 32'd9 || block1x !== 32'd5 || score !== 32'd100) begin errors++; $display("FAIL after_bad got %h %h %h exp 9 5 64", block1y, block1x, score); end
        checks++; if (block3x !== 32'd0 || block4y !== 32'd0 || blockType !== 32'd0 || screenMode !== 32'h2000_0000) begin errors++; $display("FAIL bad_untouched got %h %h %h %h", block3x, block4y, blockType, screenMode); end
        tick();
    endtask

    task automatic test_wrap_and_reset();
        while (exp_cnt < (1 << CW)) begin
            vs_n = 1'b0; tick(); exp_cnt++;
            vs_n = 1'b1; tick();
        end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap got %0d exp 0", frame_cnt); end
        do_write(4'd0, 32'd77);
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_pre_rst got %b exp 1", pending); end
        #2 reset = 1'b1;
        #1;
        checks++; if (pending !== 1'b0 || block1x !== 32'd0 || score !== 32'd0) begin errors++; $display("FAIL async_rst got p%b %h %h exp p0 0 0", pending, block1x, score); end
        checks++; if (screenMode !== MODE_RST || block1y !== 32'd0 || block2y !== 32'd0) begin errors++; $display("FAIL async_rst2 got %h %h %h", screenMode, block1y, block2y); end
        tick();
        reset = 1'b0;
        tick();
        vs_n = 1'b0; tick();
        checks++; if (frame_cnt !== 8'd1 || commit_pulse !== 1'b0 || block1x !== 32'd0) begin errors++; $display("FAIL post_rst got c%0d p%b %h exp c1 p0 0", frame_cnt, commit_pulse, block1x); end
        vs_n = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_hold();
        test_back_to_back();
        test_sel_err();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
